ifetch_ctrl: RTL



---
 rtl/ifetch_if.sv | 43 ++++
 rtl/ifetch_ctrl.sv | 75 +++++++
 2 files changed

// File: rtl/ifetch_if.sv
// Fetch-side signal bundle: instruction memory port plus the valid/ready stage toward decode.
// master = fetch controller, slave = memory/decode/branch environment.
interface ifetch_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resume;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        output mem_addr,
        input  mem_data,
        input  redirect_valid,
        input  redirect_pc,
        input  resume,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output halted,
        output fetch_count
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        output redirect_valid,
        output redirect_pc,
        output resume,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the pc, registers memory words into a one-entry
// decode-facing stage, and handles redirects and halt/resume.
//   state | meaning
//   FETCH | loading a word whenever the output stage is free or being drained
//   HALT  | halt word seen; no loads until resume or redirect
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);
    typedef enum logic {FETCH, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic handshake;
    logic load;

    assign handshake = inst_valid & bus.inst_ready;
    assign load      = (state == FETCH) && (!inst_valid || bus.inst_ready) && !bus.redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inst_valid  <= 1'b0;
            inst        <= 32'h0;
            inst_pc     <= 32'h0;
            halted      <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            if (handshake)
                fetch_count <= fetch_count + 32'd1;

            // Redirect flushes the stage even when decode accepts it this cycle.
            if (bus.redirect_valid) begin
                pc         <= {bus.redirect_pc[31:2], 2'b00};
                inst_valid <= 1'b0;
                state      <= FETCH;
                halted     <= 1'b0;
            end else if (load) begin
                inst       <= bus.mem_data;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
                pc         <= pc + 32'd4;
                if (bus.mem_data == HALT_WORD) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            end else begin
                if (handshake)
                    inst_valid <= 1'b0;
                if (state == HALT && bus.resume) begin
                    state  <= FETCH;
                    halted <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_addr    = pc;
    assign bus.inst_valid  = inst_valid;
    assign bus.inst        = inst;
    assign bus.inst_pc     = inst_pc;
    assign bus.halted      = halted;
    assign bus.fetch_count = fetch_count;
endmodule
